bsg_manycore_loopback_test_ctrl: RTL and testbench

Sequencer for the manycore loopback test node. It launches a burst of a programmed number of test requests and keeps the node's loopback path alive until every response has returned. It counts issued and returned packets, runs a no-progress watchdog, and reports a latched pass/fail verdict. It sits beside one loopback test node on the gateway board and drives that node's enables from a start/clear command interface.

---
 rtl/bsg_manycore_loopback_test_ctrl_pkg.sv | 18 +
 rtl/bsg_loopback_watchdog.sv | 38 +++
 rtl/bsg_manycore_loopback_test_ctrl.sv | 123 ++++++++++++
 tb/tb_bsg_manycore_loopback_test_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_loopback_test_ctrl_pkg.sv
// Shared types for the loopback test sequencer and the gateway status register block.
package bsg_manycore_loopback_test_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } lb_state_e;

   typedef struct packed {
      logic pass;
      logic timeout;
      logic overrun;
      logic err;
   } lb_status_s;

endpackage

// File: rtl/bsg_loopback_watchdog.sv
// Clearable saturating idle counter; expire_o pulses on the edge that takes it to all-ones.
module bsg_loopback_watchdog #(
   parameter int unsigned timeout_width_p = 12
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   localparam logic [timeout_width_p-1:0] CountMax  = '1;
   localparam logic [timeout_width_p-1:0] CountLast = {{(timeout_width_p-1){1'b1}}, 1'b0};
   localparam logic [timeout_width_p-1:0] CountInc  = {{(timeout_width_p-1){1'b0}}, 1'b1};

   logic [timeout_width_p-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != CountMax)) begin
         count_d = count_q + CountInc;
      end
   end

   // Fires on the same edge the counter lands on all-ones, not one cycle later.
   assign expire_o = !clr_i && inc_i && (count_q == CountLast);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/bsg_manycore_loopback_test_ctrl.sv
// Burst sequencer for one loopback test node: issues N requests, drains responses,
// runs a no-progress watchdog and latches a pass/fail verdict.
module bsg_manycore_loopback_test_ctrl
   import bsg_manycore_loopback_test_ctrl_pkg::*;
#(
   parameter int unsigned count_width_p   = 16,
   parameter int unsigned timeout_width_p = 12
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     start_i,
   input  logic                     clear_i,
   input  logic [count_width_p-1:0] num_pkts_i,
   output logic                     gen_en_o,
   output logic                     loop_en_o,
   input  logic                     req_v_i,
   input  logic                     req_ready_i,
   input  logic                     resp_v_i,
   input  logic                     node_error_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     pass_o,
   output logic                     timeout_o,
   output logic                     overrun_o,
   output logic [count_width_p-1:0] sent_count_o,
   output logic [count_width_p-1:0] recv_count_o
);

   localparam logic [count_width_p-1:0] CntOne = {{(count_width_p-1){1'b0}}, 1'b1};
   localparam logic [count_width_p-1:0] CntMax = '1;

   lb_state_e                state_q;
   logic [count_width_p-1:0] target_q, sent_q, recv_q;
   logic [count_width_p-1:0] sent_nxt, recv_nxt;
   logic                     timeout_q, overrun_q, err_q;
   logic                     busy, start_acc, req_hs, gen_en, sent_inc, resp_acc;
   logic                     wd_clr, wd_expire;
   lb_status_s               status;

   always_comb begin
      busy      = (state_q == StRun) || (state_q == StDrain);
      start_acc = start_i && ((state_q == StIdle) || (state_q == StDone));
      req_hs    = req_v_i && req_ready_i;
      // Registered-only compare keeps req_ready_i out of the enable path.
      gen_en    = (state_q == StRun) && (sent_q != target_q);
      sent_inc  = req_hs && gen_en;
      resp_acc  = resp_v_i && busy;
      sent_nxt  = sent_inc ? (sent_q + CntOne) : sent_q;
      recv_nxt  = (resp_acc && (recv_q != CntMax)) ? (recv_q + CntOne) : recv_q;
      wd_clr    = clear_i || start_acc || req_hs || resp_v_i;

      status.pass    = (state_q == StDone) && (recv_q == target_q) &&
                       !err_q && !timeout_q && !overrun_q;
      status.timeout = timeout_q;
      status.overrun = overrun_q;
      status.err     = err_q;
   end

   bsg_loopback_watchdog #(
      .timeout_width_p(timeout_width_p)
   ) u_watchdog (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .clr_i    (wd_clr),
      .inc_i    (busy),
      .expire_o (wd_expire)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q   <= StIdle;
         target_q  <= '0;
         sent_q    <= '0;
         recv_q    <= '0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
         err_q     <= 1'b0;
      end else if (clear_i) begin
         state_q   <= StIdle;
         sent_q    <= '0;
         recv_q    <= '0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
         err_q     <= 1'b0;
      end else if (start_acc) begin
         state_q   <= StRun;
         target_q  <= num_pkts_i;
         sent_q    <= '0;
         recv_q    <= '0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
         err_q     <= 1'b0;
      end else if (busy) begin
         sent_q <= sent_nxt;
         recv_q <= recv_nxt;
         if (resp_acc && (recv_q == sent_q)) begin
            overrun_q <= 1'b1;
         end
         if (node_error_i) begin
            err_q <= 1'b1;
         end
         if (wd_expire) begin
            timeout_q <= 1'b1;
            state_q   <= StDone;
         end else if ((state_q == StRun) && (sent_nxt == target_q)) begin
            state_q <= StDrain;
         end else if ((state_q == StDrain) && (recv_nxt == target_q)) begin
            state_q <= StDone;
         end
      end
   end

   assign gen_en_o     = gen_en;
   assign loop_en_o    = busy;
   assign busy_o       = busy;
   assign done_o       = (state_q == StDone);
   assign pass_o       = status.pass;
   assign timeout_o    = status.timeout;
   assign overrun_o    = status.overrun;
   assign sent_count_o = sent_q;
   assign recv_count_o = recv_q;

endmodule

// File: tb/tb_bsg_manycore_loopback_test_ctrl.sv
// Randomized loopback-node bench with a cycle-level behavioural model of the sequencer.
module tb_bsg_manycore_loopback_test_ctrl;

   localparam int CW       = 16;
   localparam int TW       = 12;
   localparam int MAX_IDLE = (1 << TW) - 1;
   localparam int CMAX     = (1 << CW) - 1;

   localparam int PIdle  = 0;
   localparam int PRun   = 1;
   localparam int PDrain = 2;
   localparam int PDone  = 3;

   logic          clk = 1'b0;
   logic          reset_n, start, clear, req_v, req_ready, resp_v, node_error;
   logic [CW-1:0] num_pkts;
   logic          gen_en_o, loop_en_o, busy_o, done_o, pass_o, timeout_o, overrun_o;
   logic [CW-1:0] sent_count_o, recv_count_o;

   always #5 clk = ~clk;

   bsg_manycore_loopback_test_ctrl #(
      .count_width_p  (CW),
      .timeout_width_p(TW)
   ) dut (
      .clk_i       (clk),
      .reset_n_i   (reset_n),
      .start_i     (start),
      .clear_i     (clear),
      .num_pkts_i  (num_pkts),
      .gen_en_o    (gen_en_o),
      .loop_en_o   (loop_en_o),
      .req_v_i     (req_v),
      .req_ready_i (req_ready),
      .resp_v_i    (resp_v),
      .node_error_i(node_error),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .pass_o      (pass_o),
      .timeout_o   (timeout_o),
      .overrun_o   (overrun_o),
      .sent_count_o(sent_count_o),
      .recv_count_o(recv_count_o)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural model: phase, counts and flags as plain integers.
   int m_ph = PIdle, m_tgt = 0, m_sent = 0, m_recv = 0, m_idle = 0;
   bit m_to = 0, m_ov = 0, m_er = 0;

   always @(posedge clk) begin
      if (!reset_n) begin
         m_ph = PIdle; m_tgt = 0; m_sent = 0; m_recv = 0; m_idle = 0;
         m_to = 0; m_ov = 0; m_er = 0;
      end else if (clear) begin
         m_ph = PIdle; m_sent = 0; m_recv = 0; m_idle = 0;
         m_to = 0; m_ov = 0; m_er = 0;
      end else if (start && (m_ph == PIdle || m_ph == PDone)) begin
         m_ph = PRun; m_tgt = int'(num_pkts); m_sent = 0; m_recv = 0; m_idle = 0;
         m_to = 0; m_ov = 0; m_er = 0;
      end else if (m_ph == PRun || m_ph == PDrain) begin
         if (resp_v) begin
            if (m_recv == m_sent) m_ov = 1;
            if (m_recv < CMAX) m_recv = m_recv + 1;
         end
         if (req_v && req_ready && m_ph == PRun && m_sent < m_tgt) m_sent = m_sent + 1;
         if (node_error) m_er = 1;
         if ((req_v && req_ready) || resp_v) m_idle = 0;
         else m_idle = m_idle + 1;
         if (m_idle == MAX_IDLE) begin
            m_to = 1;
            m_ph = PDone;
         end else if (m_ph == PRun && m_sent == m_tgt) begin
            m_ph = PDrain;
         end else if (m_ph == PDrain && m_recv == m_tgt) begin
            m_ph = PDone;
         end
      end
   end

   bit chk_en = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         logic [38:0] got, exp;
         logic        e_busy, e_done, e_pass, e_gen;
         e_busy = (m_ph == PRun) || (m_ph == PDrain);
         e_done = (m_ph == PDone);
         e_gen  = (m_ph == PRun) && (m_sent != m_tgt);
         e_pass = e_done && (m_recv == m_tgt) && !m_er && !m_to && !m_ov;
         exp = {e_busy, e_done, e_pass, m_to, m_ov, e_gen, e_busy, CW'(m_sent), CW'(m_recv)};
         got = {busy_o, done_o, pass_o, timeout_o, overrun_o, gen_en_o, loop_en_o,
                sent_count_o, recv_count_o};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL cycle_model t=%0t got=%h exp=%h (busy,done,pass,to,ov,gen,loop,sent,recv)",
                     $time, got, exp);
         end
      end
   end

   // Randomized loopback node.
   int pending     = 0;
   int resp_budget = -1;
   bit stall_ready = 0, hold_resp = 0, inject_resp = 0;
   bit hs_take = 0, resp_real = 0;

   always @(negedge clk) begin
      #1;
      req_v     = gen_en_o && ($urandom_range(0, 3) != 0);
      req_ready = !stall_ready && ($urandom_range(0, 3) != 0);
      resp_real = !inject_resp && !hold_resp && pending > 0 && resp_budget != 0 &&
                  ($urandom_range(0, 2) != 0);
      resp_v    = inject_resp || resp_real;
      hs_take   = req_v && req_ready && gen_en_o;
   end

   always @(posedge clk) begin
      if (reset_n) begin
         if (hs_take) pending++;
         if (resp_real) begin
            pending--;
            if (resp_budget > 0) resp_budget--;
         end
      end
   end

   task automatic check_lit(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic wait_done(input string nm, input int budget);
      int n = 0;
      while (!done_o && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!done_o) begin
         failures++;
         $display("FAIL %s_wait got=not_done exp=done within %0d cycles", nm, budget);
      end
   endtask

   task automatic wait_sent(input string nm, input int val, input int budget);
      int n = 0;
      while (int'(sent_count_o) != val && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_lit({nm, "_reach_sent"}, int'(sent_count_o), val);
   endtask

   task automatic start_burst(input int n);
      @(negedge clk);
      num_pkts = CW'(n);
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic clear_all();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear       = 1'b0;
      pending     = 0;
      resp_budget = -1;
      stall_ready = 0;
      hold_resp   = 0;
      inject_resp = 0;
   endtask

   initial begin
      #2ms;
      $display("FAIL global_time_limit got=running exp=finished");
      $fatal(1, "time limit");
   end

   initial begin
      int tgt;
      int n;
      reset_n = 0; start = 0; clear = 0; num_pkts = '0; node_error = 0;
      req_v = 0; req_ready = 0; resp_v = 0;
      repeat (3) @(negedge clk);
      reset_n = 1;
      chk_en  = 1;
      check_lit("reset_busy", int'(busy_o), 0);
      check_lit("reset_done", int'(done_o), 0);
      check_lit("reset_gen", int'(gen_en_o), 0);
      check_lit("reset_sent", int'(sent_count_o), 0);

      // Target 8, clean loopback.
      start_burst(8);
      check_lit("t8_busy_after_start", int'(busy_o), 1);
      check_lit("t8_gen_after_start", int'(gen_en_o), 1);
      wait_done("t8", 500);
      check_lit("t8_sent", int'(sent_count_o), 8);
      check_lit("t8_recv", int'(recv_count_o), 8);
      check_lit("t8_pass", int'(pass_o), 1);
      clear_all();

      // Target 5 with a 20-cycle ready stall.
      start_burst(5);
      wait_sent("t5", 2, 200);
      stall_ready = 1;
      repeat (20) @(negedge clk);
      check_lit("t5_stall_gen", int'(gen_en_o), 1);
      check_lit("t5_stall_sent", int'(sent_count_o), 2);
      stall_ready = 0;
      wait_done("t5", 500);
      check_lit("t5_sent", int'(sent_count_o), 5);
      check_lit("t5_pass", int'(pass_o), 1);
      clear_all();

      // Target 4 with one response lost: watchdog must end the burst.
      resp_budget = 3;
      start_burst(4);
      wait_done("t4_to", 6000);
      check_lit("t4_timeout", int'(timeout_o), 1);
      check_lit("t4_pass", int'(pass_o), 0);
      check_lit("t4_recv", int'(recv_count_o), 3);
      clear_all();

      // Target 3 with node error during drain.
      hold_resp = 1;
      start_burst(3);
      n = 0;
      while (!(busy_o && !gen_en_o) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_lit("t3_in_drain", int'(busy_o && !gen_en_o), 1);
      node_error = 1;
      @(negedge clk);
      node_error = 0;
      hold_resp  = 0;
      wait_done("t3", 500);
      check_lit("t3_pass", int'(pass_o), 0);
      check_lit("t3_timeout", int'(timeout_o), 0);
      clear_all();

      // Target 0, then restart from DONE with target 2.
      start_burst(0);
      check_lit("t0_busy", int'(busy_o), 1);
      check_lit("t0_gen", int'(gen_en_o), 0);
      @(negedge clk);
      check_lit("t0_not_done_yet", int'(done_o), 0);
      @(negedge clk);
      check_lit("t0_done", int'(done_o), 1);
      check_lit("t0_pass", int'(pass_o), 1);
      start_burst(2);
      check_lit("t2_restart_sent", int'(sent_count_o), 0);
      check_lit("t2_restart_busy", int'(busy_o), 1);
      wait_done("t2", 500);
      check_lit("t2_sent", int'(sent_count_o), 2);
      check_lit("t2_pass", int'(pass_o), 1);
      clear_all();

      // Reset mid-burst.
      start_burst(10);
      wait_sent("t10", 3, 300);
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      pending = 0;
      check_lit("rst_busy", int'(busy_o), 0);
      check_lit("rst_gen", int'(gen_en_o), 0);
      check_lit("rst_loop", int'(loop_en_o), 0);
      check_lit("rst_sent", int'(sent_count_o), 0);
      check_lit("rst_recv", int'(recv_count_o), 0);

      // Start and clear together in DONE.
      start_burst(1);
      wait_done("t1", 200);
      @(negedge clk);
      start = 1; clear = 1;
      @(negedge clk);
      start = 0; clear = 0;
      check_lit("sc_done", int'(done_o), 0);
      check_lit("sc_busy", int'(busy_o), 0);
      check_lit("sc_sent", int'(sent_count_o), 0);
      pending = 0;

      // Spurious response before any request.
      start_burst(2);
      inject_resp = 1;
      @(negedge clk);
      inject_resp = 0;
      wait_done("ovr", 6000);
      check_lit("ovr_flag", int'(overrun_o), 1);
      check_lit("ovr_pass", int'(pass_o), 0);
      clear_all();

      // Random bursts.
      for (int i = 0; i < 5; i++) begin
         tgt = $urandom_range(1, 16);
         start_burst(tgt);
         wait_done("rand", 1000);
         check_lit("rand_sent", int'(sent_count_o), tgt);
         check_lit("rand_pass", int'(pass_o), 1);
         clear_all();
      end

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
